// File: rtl/irq_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
package irq_sequencer_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned PLVLS_N  = 8;
    localparam int unsigned PRIV_W   = $clog2(PLVLS_N);
    localparam logic [15:0] VEC_BASE = 16'hFFC0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_PC = 3'd1,
        ST_PUSH_SR = 3'd2,
        ST_VEC_RD  = 3'd3,
        ST_POP_SR  = 3'd4,
        ST_POP_PC  = 3'd5
    } state_e;

endpackage

// File: rtl/irq_sequencer_prio_enc.sv
// Highest-index-wins priority encoder over the interrupt request lines.
module irq_prio_enc
    import irq_sequencer_pkg::*;
#(
    parameter int unsigned N = PLVLS_N,
    parameter int unsigned W = PRIV_W
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    // Scan upward so the last (highest) set line wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry (push PC/SR, fetch vector) and return (pop SR/PC) sequencer.
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int unsigned WORD  = WORD_W,
    parameter int unsigned PLVLS = PLVLS_N
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PLVLS-1:0]         irq_i,
    input  logic                     boundary_i,
    input  logic                     reti_i,
    input  logic                     ie_i,
    input  logic [$clog2(PLVLS)-1:0] currPriv_i,
    input  logic [WORD-1:0]          srData_i,
    output logic                     srWrEn_o,
    output logic                     srSetPriv_o,
    output logic [$clog2(PLVLS)-1:0] srPriv_o,
    output logic                     srClrSlp_o,
    input  logic [WORD-1:0]          pc_i,
    input  logic [WORD-1:0]          sp_i,
    output logic                     pcWr_o,
    output logic                     spWr_o,
    output logic [WORD-1:0]          sp_o,
    output logic                     stall_o,
    output logic                     memReq_o,
    output logic                     memWr_o,
    output logic [WORD-1:0]          memAddr_o,
    output logic [WORD-1:0]          memWData_o,
    input  logic [WORD-1:0]          memRData_i,
    input  logic                     memAck_i
);

    localparam int unsigned PW = $clog2(PLVLS);

    state_e          state_q, state_d;
    logic [PW-1:0]   n_q, n_d;
    logic [WORD-1:0] sp_base_q, sp_base_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] sr_q, sr_d;

    logic            enc_valid;
    logic [PW-1:0]   enc_idx;

    // Read data goes straight to PC/SR; the sequencer only times the strobes.
    logic            unused_rdata;
    assign unused_rdata = ^memRData_i;

    irq_prio_enc #(
        .N (PLVLS),
        .W (PW)
    ) u_prio_enc (
        .req_i   (irq_i),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // State and captured-context registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            sp_base_q <= '0;
            pc_q      <= '0;
            sr_q      <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            sp_base_q <= sp_base_d;
            pc_q      <= pc_d;
            sr_q      <= sr_d;
        end
    end

    // Next-state, memory request and ack-cycle strobes.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        sp_base_d   = sp_base_q;
        pc_d        = pc_q;
        sr_d        = sr_q;
        stall_o     = 1'b1;
        memReq_o    = 1'b1;
        memWr_o     = 1'b0;
        memAddr_o   = '0;
        memWData_o  = '0;
        srWrEn_o    = 1'b0;
        srSetPriv_o = 1'b0;
        srPriv_o    = '0;
        srClrSlp_o  = 1'b0;
        pcWr_o      = 1'b0;
        spWr_o      = 1'b0;
        sp_o        = '0;

        unique case (state_q)
            ST_IDLE: begin
                stall_o  = 1'b0;
                memReq_o = 1'b0;
                if (boundary_i) begin
                    if (reti_i) begin
                        sp_base_d = sp_i;
                        state_d   = ST_POP_SR;
                    end else if (ie_i && enc_valid && (enc_idx > currPriv_i)) begin
                        n_d       = enc_idx;
                        sp_base_d = sp_i;
                        pc_d      = pc_i;
                        sr_d      = srData_i;
                        state_d   = ST_PUSH_PC;
                    end
                end
            end
            ST_PUSH_PC: begin
                memWr_o    = 1'b1;
                memAddr_o  = sp_base_q - WORD'(2);
                memWData_o = pc_q;
                if (memAck_i) state_d = ST_PUSH_SR;
            end
            ST_PUSH_SR: begin
                memWr_o    = 1'b1;
                memAddr_o  = sp_base_q - WORD'(4);
                memWData_o = sr_q;
                if (memAck_i) state_d = ST_VEC_RD;
            end
            ST_VEC_RD: begin
                memAddr_o = WORD'(VEC_BASE) + WORD'({n_q, 1'b0});
                if (memAck_i) begin
                    pcWr_o      = 1'b1;
                    srSetPriv_o = 1'b1;
                    srPriv_o    = n_q;
                    srClrSlp_o  = 1'b1;
                    spWr_o      = 1'b1;
                    sp_o        = sp_base_q - WORD'(4);
                    state_d     = ST_IDLE;
                end
            end
            ST_POP_SR: begin
                memAddr_o = sp_base_q;
                if (memAck_i) begin
                    srWrEn_o = 1'b1;
                    state_d  = ST_POP_PC;
                end
            end
            ST_POP_PC: begin
                memAddr_o = sp_base_q + WORD'(2);
                if (memAck_i) begin
                    pcWr_o  = 1'b1;
                    spWr_o  = 1'b1;
                    sp_o    = sp_base_q + WORD'(4);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset silences every output and aborts the sequence.
        if (rst_i) begin
            state_d     = ST_IDLE;
            stall_o     = 1'b0;
            memReq_o    = 1'b0;
            memWr_o     = 1'b0;
            memAddr_o   = '0;
            memWData_o  = '0;
            srWrEn_o    = 1'b0;
            srSetPriv_o = 1'b0;
            srPriv_o    = '0;
            srClrSlp_o  = 1'b0;
            pcWr_o      = 1'b0;
            spWr_o      = 1'b0;
            sp_o        = '0;
        end
    end

endmodule
